// File: rtl/core_muldiv_unit_pkg.sv
// muldiv_control_pkg
// Types and helpers for the iterative RV32M multiply/divide unit.
//   muldiv_op_t        : funct3 encoding of the M-extension operations
//   muldiv_state_t     : controller states
//   muldiv_step_mode_t : selects multiply or divide behaviour of one iteration
//   MULDIV_CNT_W       : width of the iteration counter
package muldiv_control_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } muldiv_step_mode_t;

  localparam int MULDIV_CNT_W = $clog2(core_pkg::DATA_WIDTH);

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {REM, REMU};
  endfunction

endpackage

// File: rtl/core_pkg.sv
// core_pkg
// Core-wide constants shared by the execution-stage blocks.
//   DATA_WIDTH : integer register / operand width.
package core_pkg;

  localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/core_muldiv_unit_if.sv
// core_muldiv_unit_if
// Request/response bundle between the execution stage and the mul/div unit.
//   muldiv_start  : request strobe (held by requester until busy is low)
//   muldiv_op     : operation, funct3 encoding
//   muldiv_in_a/b : rs1 / rs2 operands
//   muldiv_kill   : pipeline flush, aborts any operation
//   muldiv_busy   : unit is working, pipeline must stall
//   muldiv_done   : one-cycle result-valid pulse
//   muldiv_out    : result, held until the next accepted start
// Modports: master = pipeline side, slave = mul/div unit.
interface core_muldiv_unit_if #(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
);
  import muldiv_control_pkg::*;

  logic                  muldiv_start;
  muldiv_op_t            muldiv_op;
  logic [DATA_WIDTH-1:0] muldiv_in_a;
  logic [DATA_WIDTH-1:0] muldiv_in_b;
  logic                  muldiv_kill;
  logic                  muldiv_busy;
  logic                  muldiv_done;
  logic [DATA_WIDTH-1:0] muldiv_out;

  modport master (
    output muldiv_start, muldiv_op, muldiv_in_a, muldiv_in_b, muldiv_kill,
    input  muldiv_busy, muldiv_done, muldiv_out
  );

  modport slave (
    input  muldiv_start, muldiv_op, muldiv_in_a, muldiv_in_b, muldiv_kill,
    output muldiv_busy, muldiv_done, muldiv_out
  );

endinterface

// File: rtl/core_muldiv_step.sv
// core_muldiv_step
// One combinational iteration of the shift-add multiplier / restoring divider.
// A single DATA_WIDTH+1-bit adder/subtractor serves both modes.
//   acc      : in  2*DATA_WIDTH accumulator
//   operand  : in  multiplicand (multiply) or divisor (divide) magnitude
//   mode     : in  STEP_MUL or STEP_DIV
//   acc_next : out accumulator after this iteration
// Multiply: low half holds the remaining multiplier bits, high half the partial
// product; add when the multiplier LSB is set, then shift right with carry.
// Divide: high half is the partial remainder, low half the dividend bits that
// turn into quotient bits; shift left, keep the subtraction if it did not borrow.
module core_muldiv_step
  import muldiv_control_pkg::*;
#(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  muldiv_step_mode_t       mode,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH;

  logic          sub;
  logic [DW:0]   add_x;
  logic [DW:0]   add_y;
  logic [DW+1:0] add_sum;

  always_comb begin
    sub     = (mode == STEP_DIV);
    // divide operates on the remainder already shifted left by one
    add_x   = sub ? acc[AW-1:DW-1] : {1'b0, acc[AW-1:DW]};
    add_y   = {1'b0, operand};
    // x - y as x + ~y + 1; bit DW+1 is the carry, set when x >= y
    add_sum = {1'b0, add_x} + {1'b0, (sub ? ~add_y : add_y)} + {{(DW+1){1'b0}}, sub};

    acc_next = '0;
    if (sub) begin
      if (add_sum[DW+1]) acc_next = {add_sum[DW-1:0], acc[DW-2:0], 1'b1};
      else               acc_next = {acc[AW-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_next = {add_sum[DW:0], acc[DW-1:1]};
      else        acc_next = {1'b0, acc[AW-1:1]};
    end
  end

endmodule

// File: rtl/core_muldiv_unit.sv
// core_muldiv_unit
// Iterative RV32M multiply/divide controller beside the single-cycle ALU.
// Operands are converted to magnitudes on acceptance, iterated DATA_WIDTH times
// through core_muldiv_step, then sign-corrected and registered in FIX.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : core_muldiv_unit_if.slave (start/op/a/b/kill in, busy/done/out out)
// Build option CORE_MULDIV_DIV_EN: when defined the divide datapath and the
// divide-by-zero / overflow fast path are present; when undefined divide ops
// are accepted and return 0 with done in cycle 2.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | operands latched; pick fast path or load accumulator
// CALC  | one shift-add / shift-subtract iteration per cycle
// FIX   | sign correction and result word selection
// DONE  | result valid, done pulse; back-to-back start accepted here
module core_muldiv_unit
  import muldiv_control_pkg::*;
#(
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  core_muldiv_unit_if.slave bus
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = 2 * DATA_WIDTH;
  localparam int CNT_W = MULDIV_CNT_W;

  muldiv_state_t     state;
  muldiv_op_t        op_q;
  logic              sa_q;
  logic              sb_q;
  logic [DW-1:0]     a_mag_q;
  logic [DW-1:0]     b_mag_q;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_step;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [DW-1:0]     out_q;
  muldiv_step_mode_t step_mode;

  logic          sa_in;
  logic          sb_in;
  logic [DW-1:0] a_mag_in;
  logic [DW-1:0] b_mag_in;

  always_comb begin
    sa_in    = (bus.muldiv_op inside {MULH, MULHSU, DIV, REM}) & bus.muldiv_in_a[DW-1];
    sb_in    = (bus.muldiv_op inside {MULH, DIV, REM}) & bus.muldiv_in_b[DW-1];
    a_mag_in = sa_in ? (-bus.muldiv_in_a) : bus.muldiv_in_a;
    b_mag_in = sb_in ? (-bus.muldiv_in_b) : bus.muldiv_in_b;
  end

`ifdef CORE_MULDIV_DIV_EN
  assign step_mode = is_div(op_q) ? STEP_DIV : STEP_MUL;
`else
  assign step_mode = STEP_MUL;
`endif

  core_muldiv_step #(.DATA_WIDTH(DW)) u_step (
    .acc      (acc_q),
    .operand  (b_mag_q),
    .mode     (step_mode),
    .acc_next (acc_step)
  );

  logic [AW-1:0] prod_s;
  logic [DW-1:0] fix_res;
`ifdef CORE_MULDIV_DIV_EN
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};
  logic [DW-1:0] quo_s;
  logic [DW-1:0] rem_s;
  logic [DW-1:0] a_orig;
  logic          fast_zero;
  logic          fast_ovf;
  logic [DW-1:0] fast_res;
`endif

  always_comb begin
    prod_s  = (sa_q ^ sb_q) ? (-acc_q) : acc_q;
    fix_res = (op_q == MUL) ? prod_s[DW-1:0] : prod_s[AW-1:DW];
`ifdef CORE_MULDIV_DIV_EN
    quo_s = (sa_q ^ sb_q) ? (-acc_q[DW-1:0]) : acc_q[DW-1:0];
    rem_s = sa_q ? (-acc_q[AW-1:DW]) : acc_q[AW-1:DW];
    if (is_div(op_q)) fix_res = is_rem(op_q) ? rem_s : quo_s;

    // the original rs1 value is rebuilt from magnitude and sign
    a_orig    = sa_q ? (-a_mag_q) : a_mag_q;
    fast_zero = is_div(op_q) && (b_mag_q == '0);
    fast_ovf  = (op_q inside {DIV, REM}) && sa_q && sb_q &&
                (a_mag_q == MOST_NEG) && (b_mag_q == ONE);
    if (fast_zero) fast_res = is_rem(op_q) ? a_orig : '1;
    else           fast_res = is_rem(op_q) ? '0 : a_orig;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else if (bus.muldiv_kill) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.muldiv_start) begin
            state   <= PREP;
            busy_q  <= 1'b1;
            op_q    <= bus.muldiv_op;
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            a_mag_q <= a_mag_in;
            b_mag_q <= b_mag_in;
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
`ifdef CORE_MULDIV_DIV_EN
          if (fast_zero || fast_ovf) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            out_q  <= fast_res;
          end else
`else
          if (is_div(op_q)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            out_q  <= '0;
          end else
`endif
          begin
            acc_q <= {{DW{1'b0}}, a_mag_q};
            cnt_q <= CNT_W'(DW - 1);
            state <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state <= FIX;
        end
        FIX: begin
          out_q  <= fix_res;
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.muldiv_busy = busy_q;
  assign bus.muldiv_done = done_q;
  assign bus.muldiv_out  = out_q;

endmodule

// File: tb/tb_core_muldiv_unit.sv
// tb_core_muldiv_unit
// Directed bench for core_muldiv_unit. A cycle-level reference model derives
// results from the RV32M arithmetic rules and latency from the operation class;
// a compare process checks busy/done/out every cycle against it, and the
// directed sequence pins the model with hand-computed results and latencies.
module tb_core_muldiv_unit;
  import muldiv_control_pkg::*;

  localparam int DW = 32;
`ifdef CORE_MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  core_muldiv_unit_if #(.DATA_WIDTH(DW)) mif ();

  core_muldiv_unit #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // result and latency (cycles from acceptance edge to done) from the ISA rules
  function automatic void eval(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r, output int lat);
    longint          p;
    longint unsigned pu;
    lat = DW + 3;
    r   = '0;
    case (op)
      MUL:    begin p = longint'($signed(a)) * longint'($signed(b)); r = p[31:0]; end
      MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
      MULHSU: begin p = longint'($signed(a)) * longint'({32'b0, b}); r = p[63:32]; end
      MULHU:  begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
      default: begin
`ifdef CORE_MULDIV_DIV_EN
        if (b == 32'd0) begin
          lat = 2;
          r   = (op inside {REM, REMU}) ? a : 32'hFFFF_FFFF;
        end else if ((op inside {DIV, REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lat = 2;
          r   = (op == REM) ? 32'd0 : a;
        end else begin
          case (op)
            DIV:     r = $signed(a) / $signed(b);
            REM:     r = $signed(a) % $signed(b);
            DIVU:    r = a / b;
            default: r = a % b;
          endcase
        end
`else
        lat = 2;
        r   = '0;
`endif
      end
    endcase
  endfunction

  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  logic [31:0] m_out    = '0;
  logic [31:0] m_res    = '0;
  int          m_left   = 0;

  always @(posedge clk or negedge rst_n) begin
    int lat;
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_out    = '0;
      m_left   = 0;
    end else if (mif.muldiv_kill) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (m_active) begin
      m_done = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_out    = m_res;
      end
    end else begin
      m_done = 1'b0;
      if (mif.muldiv_start) begin
        eval(mif.muldiv_op, mif.muldiv_in_a, mif.muldiv_in_b, m_res, lat);
        m_left   = lat - 1;
        m_active = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model busy", {31'b0, mif.muldiv_busy}, {31'b0, m_active});
      chk("model done", {31'b0, mif.muldiv_done}, {31'b0, m_done});
      chk("model out", mif.muldiv_out, m_out);
      chk("busy&done exclusive", {31'b0, mif.muldiv_busy & mif.muldiv_done}, 32'd0);
    end
  end

  // caller sits just after a rising edge; returns in cycle 1 of the operation
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    mif.muldiv_start = 1'b1;
    mif.muldiv_op    = op;
    mif.muldiv_in_a  = a;
    mif.muldiv_in_b  = b;
    @(posedge clk); #1;
    mif.muldiv_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (mif.muldiv_done !== 1'b1 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int n;
    issue(op, a, b);
    wait_done(n);
    chk({name, " result"}, mif.muldiv_out, exp_r);
    chk({name, " done cycle"}, n, exp_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    mif.muldiv_start = 1'b0;
    mif.muldiv_op    = MUL;
    mif.muldiv_in_a  = '0;
    mif.muldiv_in_b  = '0;
    mif.muldiv_kill  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, mif.muldiv_busy}, 32'd0);
    chk("reset done", {31'b0, mif.muldiv_done}, 32'd0);
    chk("reset out", mif.muldiv_out, 32'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(posedge clk); #1;

    run_op("MUL 7*-7", MUL, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFCF, 35);
    run_op("MULH min*min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35);
    run_op("MULHSU -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
    run_op("MULHU max*max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
    run_op("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2, DIV_ON ? 32'hFFFF_FFFD : 32'd0, DIV_ON ? 35 : 2);
    run_op("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2, DIV_ON ? 32'hFFFF_FFFF : 32'd0, DIV_ON ? 35 : 2);
    run_op("DIVU 100/7", DIVU, 32'd100, 32'd7, DIV_ON ? 32'd14 : 32'd0, DIV_ON ? 35 : 2);
    run_op("DIV 100/7", DIV, 32'd100, 32'd7, DIV_ON ? 32'd14 : 32'd0, DIV_ON ? 35 : 2);
    run_op("DIVU by 0", DIVU, 32'd100, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'd0, 2);
    run_op("REMU by 0", REMU, 32'd100, 32'd0, DIV_ON ? 32'd100 : 32'd0, 2);
    run_op("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_ON ? 32'h8000_0000 : 32'd0, 2);
    run_op("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    run_op("MUL 3*5", MUL, 32'd3, 32'd5, 32'd15, 35);

    // kill in cycle 10 of a MUL, restart in cycle 11
    issue(MUL, 32'd1234, 32'd5678);
    repeat (9) begin @(posedge clk); #1; end
    mif.muldiv_kill = 1'b1;
    @(posedge clk); #1;
    mif.muldiv_kill = 1'b0;
    chk("kill busy low", {31'b0, mif.muldiv_busy}, 32'd0);
    chk("kill out held", mif.muldiv_out, 32'd15);
    issue(MULHU, 32'h0001_0000, 32'h0003_0000);
    wait_done(n);
    chk("post-kill result", mif.muldiv_out, 32'd3);
    chk("post-kill done cycle", n, 35);

    // back-to-back: start in the done cycle
    issue(MUL, 32'd1000, 32'd1000);
    wait_done(n);
    chk("b2b first result", mif.muldiv_out, 32'd1_000_000);
    issue(MULH, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("b2b busy next cycle", {31'b0, mif.muldiv_busy}, 32'd1);
    wait_done(n);
    chk("b2b second result", mif.muldiv_out, 32'hFFFF_FFFF);
    chk("b2b second done cycle", n, 35);
    @(posedge clk); #1;

    // asynchronous reset in cycle 20
    issue(MUL, 32'd9, 32'd9);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", {31'b0, mif.muldiv_busy}, 32'd0);
    chk("mid reset done", {31'b0, mif.muldiv_done}, 32'd0);
    chk("mid reset out", mif.muldiv_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("MUL after reset", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 35);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_muldiv_unit.md
# core_muldiv_unit

Iterative RV32M multiply/divide controller in the execution stage, beside the single-cycle ALU. It accepts one operation at a time and sequences a shared add/subtract step over DATA_WIDTH iterations. It applies RISC-V sign and corner-case rules and returns the result with a one-cycle done pulse. The pipeline stalls on busy.

## Interface
- DATA_WIDTH, core_pkg::DATA_WIDTH (32), operand/result width; must be a power of two ≥ 8
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- muldiv_start  in  1  request strobe; accepted only in IDLE or DONE
- muldiv_op  in  3  muldiv_op_t, funct3 encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- muldiv_in_a  in  DATA_WIDTH  rs1 value, sampled on acceptance
- muldiv_in_b  in  DATA_WIDTH  rs2 value, sampled on acceptance
- muldiv_kill  in  1  synchronous abort (pipeline flush)
- muldiv_busy  out  1  high while in PREP, CALC or FIX
- muldiv_done  out  1  one-cycle pulse, result valid
- muldiv_out  out  DATA_WIDTH  result; held from done until the next accepted start

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- Reset values: state IDLE, busy 0, done 0, muldiv_out 0, iteration counter 0.
- IDLE/DONE + start (no kill) → PREP. Latch op, sign flags and |a|, |b|.
  - Signedness: MULH/DIV/REM treat both operands as signed. MULHSU treats only a as signed. All other ops are unsigned.
- PREP → DONE (fast path) when the op is divide/remainder and either condition below holds. Otherwise PREP → CALC with counter = DATA_WIDTH-1.
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow, i.e. DIV/REM with a = most-negative and b = -1: DIV gives a; REM gives 0.
- CALC, one iteration per cycle through core_muldiv_step; the counter decrements and the state exits after the iteration where the counter is 0.
  - Multiply: shift-add into a 2·DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract, with remainder in the upper half and quotient in the lower half.
- FIX: negate the magnitude result if the result sign is set, then select the output word.
  - Product sign: sa^sb.
  - Quotient sign: sa^sb.
  - Remainder sign: sa.
  - MUL selects the low word. MULH/MULHSU/MULHU select the high word.
- FIX → DONE: muldiv_out registered, done=1 for exactly one cycle.
- DONE → IDLE, or → PREP if start is asserted in the DONE cycle (back-to-back).
- Kill is honoured in any state and takes priority over start in the same cycle.
  - Next state is IDLE.
  - busy falls next cycle.
  - No done is produced.
  - muldiv_out keeps its previous value.
- start while busy is ignored. The requester must hold start until busy is low.

## Timing
- Start accepted at edge 0 → PREP in cycle 1 → CALC in cycles 2..DATA_WIDTH+1 → FIX in cycle DATA_WIDTH+2 → done in cycle DATA_WIDTH+3 (35 for DATA_WIDTH=32).
- Fast path: done in cycle 2.
- busy is high in cycles 1 through the cycle before done. busy and done are never high together.
- Back-to-back issue: start asserted in the done cycle makes busy high in the next cycle.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous); no done.

## Configuration
- CORE_MULDIV_DIV_EN defined: full M extension as above.
- CORE_MULDIV_DIV_EN undefined: divide datapath and fast-path logic are compiled out.
  - DIV/DIVU/REM/REMU are still accepted, go PREP → DONE, and return 0 with done in cycle 2.
  - Multiply behaviour and timing are unchanged.

## Structure
- New package muldiv_control_pkg contains:
  - muldiv_op_t (3-bit enum, funct3 values)
  - muldiv_state_t (IDLE/PREP/CALC/FIX/DONE)
  - MULDIV_CNT_W = $clog2(DATA_WIDTH)
- DATA_WIDTH comes from core_pkg.
- Sub-module core_muldiv_step: combinational single iteration.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator, computed with one shared DATA_WIDTH+1-bit adder/subtractor used for both add and subtract.
- FSM, counter, sign handling and output register live in core_muldiv_unit.

## Test plan
- MUL 7 × 0xFFFFFFF9 (−7) → 0xFFFFFFCF (−49); done in cycle 35, exactly one pulse; busy high in cycles 1–34.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14.
- DIVU 100 / 0 → 0xFFFFFFFF and REMU 100 / 0 → 100; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0; each with done in cycle 2.
- Kill in cycle 10 of a MUL → busy low in cycle 11, no done, muldiv_out unchanged. A new start in cycle 11 completes normally.
- Start asserted in the done cycle → second op accepted with no idle gap. Reset asserted in cycle 20 → busy/done/out = 0 immediately.
- With CORE_MULDIV_DIV_EN undefined: DIV 100 / 7 → 0 with done in cycle 2.
